// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply controller.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned CNT_W     = $clog2(16);

endpackage

// File: rtl/mul_hilo_ctrl.sv
// Multicycle controller for the external combinational multiplier plus HI/LO registers.
// Optional sticky signed-overflow flag enabled by defining MUL_HILO_OVF_EN.
module mul_hilo_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH      = MUL_WIDTH,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    input  logic               hi_wr,
    input  logic               lo_wr,
    input  logic [WIDTH-1:0]   bus_in,
    output logic [WIDTH-1:0]   hi_out,
    output logic [WIDTH-1:0]   lo_out,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               capture;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        capture = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    cnt_d   = CNT_W'(MUL_CYCLES - 1);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus writes first so that a same-edge product capture overrides them.
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_wr) hi_d = bus_in;
        if (lo_wr) lo_d = bus_in;
        if (capture) begin
            hi_d = mul_p[2*WIDTH-1:WIDTH];
            lo_d = mul_p[WIDTH-1:0];
        end
    end

`ifdef MUL_HILO_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (hi_wr || lo_wr) ovf_d = 1'b0;
        if (capture && (mul_p[2*WIDTH-1:WIDTH] != {WIDTH{mul_p[WIDTH-1]}})) ovf_d = 1'b1;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign mul_a  = a_q;
    assign mul_b  = b_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench: two controllers (MUL_CYCLES=4 and 1) against a countdown reference model.
module tb_mul_hilo_ctrl;

`ifdef MUL_HILO_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear_n, start, abort, hi_wr, lo_wr;
    logic [31:0] op_a, op_b, bus_in;

    logic [31:0] mul_a0, mul_b0, hi0, lo0, mul_a1, mul_b1, hi1, lo1;
    logic [63:0] mul_p0, mul_p1;
    logic        busy0, done0, ovf0, busy1, done1, ovf1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // Stand-ins for the external combinational signed multiplier.
    assign mul_p0 = $signed({{32{mul_a0[31]}}, mul_a0}) * $signed({{32{mul_b0[31]}}, mul_b0});
    assign mul_p1 = $signed({{32{mul_a1[31]}}, mul_a1}) * $signed({{32{mul_b1[31]}}, mul_b1});

    mul_hilo_ctrl #(.WIDTH(32), .MUL_CYCLES(4)) u_dut4 (
        .clock(clock), .clear_n(clear_n), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .bus_in(bus_in), .hi_out(hi0), .lo_out(lo0),
        .busy(busy0), .done(done0), .ovf(ovf0)
    );

    mul_hilo_ctrl #(.WIDTH(32), .MUL_CYCLES(1)) u_dut1 (
        .clock(clock), .clear_n(clear_n), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .bus_in(bus_in), .hi_out(hi1), .lo_out(lo1),
        .busy(busy1), .done(done1), .ovf(ovf1)
    );

    // Reference model: rem = edges left until capture (-1 when not multiplying).
    int          mc[2] = '{4, 1};
    int          rem[2];
    bit          dn[2];
    bit          m_ov[2];
    logic [31:0] m_a[2], m_b[2], m_hi[2], m_lo[2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i] = -1; dn[i] = 1'b0; m_ov[i] = 1'b0;
            m_a[i] = '0; m_b[i] = '0; m_hi[i] = '0; m_lo[i] = '0;
        end
    endfunction

    function automatic void model_step();
        if (!clear_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            bit          cap = 1'b0;
            longint      sa, sb;
            logic [63:0] p = '0;
            dn[i] = 1'b0;
            if (rem[i] >= 0) begin
                if (abort) rem[i] = -1;
                else if (rem[i] == 0) begin
                    sa = $signed(m_a[i]);
                    sb = $signed(m_b[i]);
                    p = sa * sb;
                    cap = 1'b1;
                    rem[i] = -1;
                    dn[i] = 1'b1;
                end else rem[i]--;
            end else if (start) begin
                m_a[i] = op_a;
                m_b[i] = op_b;
                rem[i] = mc[i] - 1;
            end
            if (cap) begin
                m_hi[i] = p[63:32];
                m_lo[i] = p[31:0];
            end else begin
                if (hi_wr) m_hi[i] = bus_in;
                if (lo_wr) m_lo[i] = bus_in;
            end
            if (OVF_ON) begin
                if (hi_wr || lo_wr) m_ov[i] = 1'b0;
                if (cap && (p[63:32] != {32{p[31]}})) m_ov[i] = 1'b1;
            end
        end
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("i0_busy", busy0, rem[0] >= 0);
        check_eq("i0_done", done0, dn[0]);
        check_eq("i0_hi", hi0, m_hi[0]);
        check_eq("i0_lo", lo0, m_lo[0]);
        check_eq("i0_ovf", ovf0, m_ov[0]);
        check_eq("i0_mula", mul_a0, m_a[0]);
        check_eq("i0_mulb", mul_b0, m_b[0]);
        check_eq("i1_busy", busy1, rem[1] >= 0);
        check_eq("i1_done", done1, dn[1]);
        check_eq("i1_hi", hi1, m_hi[1]);
        check_eq("i1_lo", lo1, m_lo[1]);
        check_eq("i1_ovf", ovf1, m_ov[1]);
        check_eq("i1_mula", mul_a1, m_a[1]);
        check_eq("i1_mulb", mul_b1, m_b[1]);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, d1, d2;
        clear_n = 1'b0; start = 1'b0; abort = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        op_a = '0; op_b = '0; bus_in = '0;
        model_reset();
        @(negedge clock);
        check_all();
        check_eq("reset_hi", hi0, 0);
        clear_n = 1'b1;
        cycle(); cycle();

        // Reset in the middle of a multiply
        op_a = 5; op_b = 6; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle(); cycle();
        clear_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_eq("midrst_busy", busy0, 0);
        check_eq("midrst_done", done0, 0);
        check_eq("midrst_mula", mul_a0, 0);
        cycle();
        clear_n = 1'b1;
        cycle();

        // Basic multiply 7 * -3
        op_a = 7; op_b = 32'hFFFF_FFFD; start = 1'b1;
        cycle();
        start = 1'b0;
        check_eq("basic_busy", busy0, 1);
        k = 0;
        while (!done0 && k < 12) begin cycle(); k++; end
        check_eq("basic_latency", k, 4);
        check_eq("basic_hi", hi0, 32'hFFFF_FFFF);
        check_eq("basic_lo", lo0, 32'hFFFF_FFEB);
        check_eq("basic_ovf", ovf0, 0);
        cycle(); cycle();

        // Back-to-back with start held high
        op_a = 32'h0001_0000; op_b = 32'h0001_0000; start = 1'b1;
        cycle();
        op_a = 2; op_b = 3;
        d1 = -1; d2 = -1;
        for (int c = 1; c <= 14; c++) begin
            cycle();
            if (done0) begin
                if (d1 < 0) begin
                    d1 = c;
                    check_eq("b2b_hi1", hi0, 32'h1);
                    check_eq("b2b_lo1", lo0, 32'h0);
                    check_eq("b2b_ovf1", ovf0, OVF_ON);
                end else if (d2 < 0) begin
                    d2 = c;
                    check_eq("b2b_hi2", hi0, 32'h0);
                    check_eq("b2b_lo2", lo0, 32'h6);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_eq("b2b_gap", d2 - d1, 5);
        cycle(); cycle();

        // Abort in second RUN cycle; start during RUN ignored
        op_a = 9; op_b = 9; start = 1'b1;
        cycle();
        op_a = 1; op_b = 1;
        cycle();
        check_eq("abort_held_a", mul_a0, 9);
        start = 1'b0; abort = 1'b1;
        cycle();
        abort = 1'b0;
        check_eq("abort_busy", busy0, 0);
        check_eq("abort_hi", hi0, 32'h0);
        check_eq("abort_lo", lo0, 32'h6);
        for (int c = 0; c < 6; c++) begin
            cycle();
            check_eq("abort_nodone", done0, 0);
        end

        // Bus write colliding with capture
        op_a = 3; op_b = 4; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle(); cycle(); cycle();
        hi_wr = 1'b1; bus_in = 32'hDEAD_BEEF;
        cycle();
        check_eq("coll_done", done0, 1);
        check_eq("coll_hi", hi0, 32'h0);
        check_eq("coll_lo", lo0, 32'hC);
        cycle();
        hi_wr = 1'b0;
        check_eq("wr_hi", hi0, 32'hDEAD_BEEF);
        check_eq("wr_ovf", ovf0, 0);
        cycle(); cycle();

        // MUL_CYCLES=1 instance, most-negative squared
        op_a = 32'h8000_0000; op_b = 32'h8000_0000; start = 1'b1;
        cycle();
        start = 1'b0;
        check_eq("mc1_busy", busy1, 1);
        cycle();
        check_eq("mc1_done", done1, 1);
        check_eq("mc1_hi", hi1, 32'h4000_0000);
        check_eq("mc1_lo", lo1, 32'h0);
        check_eq("mc1_ovf", ovf1, OVF_ON);
        for (int c = 0; c < 5; c++) cycle();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            clear_n = ($urandom_range(0, 79) != 0);
            start   = ($urandom_range(0, 2) == 0);
            abort   = ($urandom_range(0, 9) == 0);
            hi_wr   = ($urandom_range(0, 7) == 0);
            lo_wr   = ($urandom_range(0, 7) == 0);
            bus_in  = $urandom;
            op_a    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20);
            op_b    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_hilo_ctrl.md
Name: mul_hilo_ctrl

Overview:
- Multicycle controller for the combinational signed multiplier `mul_32bit`.
- Latches operands from the datapath and holds them stable on the multiplier inputs for MUL_CYCLES settling cycles.
- Captures the 64-bit product into the HI/LO registers and signals completion to the control unit.
- Also serves the mthi/mtlo bus writes and the mfhi/mflo reads.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- MUL_CYCLES, 4, cycles operands are held before product capture; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  request multiply; sampled in IDLE or DONE only.
- abort  in  1  cancel an in-flight multiply.
- op_a  in  WIDTH  multiplicand from datapath (Y register).
- op_b  in  WIDTH  multiplier from bus.
- mul_a  out  WIDTH  latched multiplicand to `mul_32bit`.a.
- mul_b  out  WIDTH  latched multiplier to `mul_32bit`.b.
- mul_p  in  2*WIDTH  product from `mul_32bit`.p.
- hi_wr  in  1  bus write enable, HI (mthi).
- lo_wr  in  1  bus write enable, LO (mtlo).
- bus_in  in  WIDTH  bus write data.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- ovf  out  1  sticky signed-overflow flag (see Optional Feature).

Behaviour:
- Reset: clear_n low asynchronously forces state=IDLE and counter=0. It also zeroes mul_a, mul_b, hi_out, lo_out, busy, done and ovf. This holds in every state, including mid-RUN.
- States: IDLE, RUN, DONE. busy is high only in RUN; done is high only in DONE. Both are decoded from registered state.
- IDLE:
  - start=1 latches op_a→mul_a and op_b→mul_b, loads cnt=MUL_CYCLES-1, and moves to RUN.
  - Otherwise stays in IDLE.
- RUN:
  - mul_a and mul_b are held constant.
  - abort=1 has priority: go to IDLE, HI/LO unchanged, no done pulse.
  - Else if cnt==0: hi_out←mul_p[63:32], lo_out←mul_p[31:0], go to DONE.
  - Else cnt←cnt-1.
- DONE:
  - Lasts exactly one cycle; HI/LO already hold the new product.
  - start=1 here begins a new multiply, as from IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: with start sampled at edge 0, the product is captured at edge MUL_CYCLES and done is high in the following cycle. Back-to-back multiplies therefore issue every MUL_CYCLES+1 cycles.
- start while busy: ignored, not queued.
- Bus writes:
  - hi_wr/lo_wr load bus_in into HI/LO in any state.
  - On the product-capture edge, the capture wins over a simultaneous hi_wr/lo_wr.
  - hi_wr and lo_wr together write both registers.
- Arithmetic: product is two's-complement signed, as produced by `mul_32bit`. This block performs no arithmetic on it beyond the split into HI/LO.
- abort in IDLE or DONE: no effect.

Optional Feature:
- Macro: MUL_HILO_OVF_EN.
- Defined: on each product capture, ovf is set if mul_p[63:32] != {32{mul_p[31]}}, i.e. the product is not representable in 32 signed bits. ovf is sticky and is cleared by clear_n or by any hi_wr/lo_wr.
- Undefined: ovf is tied 0 and the comparison logic is absent.

Decomposition:
- Package mul_pkg:
  - state enum (IDLE, RUN, DONE);
  - WIDTH default;
  - counter width constant, $clog2(16).
- No sub-module. `mul_32bit` is instantiated by the enclosing datapath and connected through mul_a/mul_b/mul_p, not inside this block.

Test Plan:
- Reset mid-RUN: start with op_a=5, op_b=6, then pull clear_n low two cycles later → all outputs 0, state IDLE, no done pulse.
- Basic multiply: op_a=7, op_b=0xFFFFFFFD (-3), start, MUL_CYCLES=4 → busy for 4 cycles; done in the 5th cycle after start; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; ovf=0.
- Back-to-back: start held high for 0x10000×0x10000 followed by 2×3 → done pulses exactly 5 cycles apart. First result HI=0x1, LO=0x0 (ovf=1 when MUL_HILO_OVF_EN is defined); second result HI=0, LO=6.
- Abort: start 9×9, abort in 2nd RUN cycle → returns to IDLE, HI/LO keep prior values, no done pulse. A start during RUN before the abort is ignored.
- Write collision: hi_wr=1 with bus_in=0xDEADBEEF on the capture edge of 3×4 → hi_out=0, lo_out=0xC. A hi_wr one cycle later → hi_out=0xDEADBEEF, and ovf clears.
- Edge MUL_CYCLES=1: start 0x80000000×0x80000000 → done 2 cycles after start; HI=0x40000000, LO=0; ovf=1 with the macro defined, 0 without.
